// File: rtl/spi_serf_pkg.sv
// Shared types and constants for the 16-bit SPI serf that emulates the IMU end of the link.
// The frame is a command byte ({R/W, addr[6:0]}) followed by a data byte, sent MSB first.
package spi_serf_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2,
        HOLD = 2'd3
    } state_t;

    localparam logic [6:0] ADDR_WHO  = 7'h0F;
    localparam logic [6:0] ADDR_YAWL = 7'h26;
    localparam logic [6:0] ADDR_YAWH = 7'h27;

    localparam int FRAME_BITS = 16;
    localparam int CMD_BITS   = 8;

    // bit_cnt values that mark the last command bit, the last frame bit and the first tx shift
    localparam logic [4:0] LAST_CMD_BIT    = 5'(CMD_BITS - 1);
    localparam logic [4:0] LAST_FRAME_BIT  = 5'(FRAME_BITS - 1);
    localparam logic [4:0] FIRST_SHIFT_BIT = 5'(CMD_BITS + 1);

endpackage

// File: rtl/spi_edge_sync.sv
// Two-flop synchroniser for an asynchronous input plus a third flop for edge detection.
// rise/fall are single-clk pulses aligned with the synchronised level.
module spi_edge_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out,
    output logic rise,
    output logic fall
);

    logic [2:0] sync_q;

    // NOTE: sequential state is always updated with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {3{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[1:0], async_in};
        end
    end

    assign sync_out = sync_q[1];
    assign rise     = sync_q[1] & ~sync_q[2];
    assign fall     = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/spi_serf_imu.sv
// SPI serf modelling the inertial sensor: WHO_AM_I, a control register that arms nemo_setup,
// and a yaw-rate sample with a data-ready interrupt cleared by reading the high byte.
module spi_serf_imu
    import spi_serf_pkg::*;
#(
    parameter logic [7:0] WHO_AM_I_VAL = 8'h6A,
    parameter logic [7:0] SETUP_VAL    = 8'h02,
    parameter logic [6:0] ADDR_CTRL    = 7'h0D
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        SS_n,
    input  logic        SCLK,
    input  logic        MOSI,
    output logic        MISO,
    output logic        INT,
    output logic        nemo_setup,
    input  logic        yaw_vld,
    input  logic [15:0] yaw_data,
    output logic        done
);

    logic       ss_sync;
    logic       ss_fall;
    logic       ss_rise_unused;
    logic       sclk_sync_unused;
    logic       sclk_rise;
    logic       sclk_fall;
    logic [1:0] mosi_q;
    logic       mosi_s;

    spi_edge_sync #(.RESET_VAL(1'b1)) u_ss_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (SS_n),
        .sync_out (ss_sync),
        .rise     (ss_rise_unused),
        .fall     (ss_fall)
    );

    spi_edge_sync #(.RESET_VAL(1'b1)) u_sclk_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (SCLK),
        .sync_out (sclk_sync_unused),
        .rise     (sclk_rise),
        .fall     (sclk_fall)
    );

    // MOSI shares the SCLK synchroniser depth so it is stable when sclk_rise fires
    always_ff @(posedge clk) begin
        if (rst) begin
            mosi_q <= 2'b11;
        end else begin
            mosi_q <= {mosi_q[0], MOSI};
        end
    end
    assign mosi_s = mosi_q[1];

    state_t     state;
    logic [4:0] bit_cnt;
    logic [6:0] rx_shft;
    logic [7:0] tx_shft;
    logic       rw;
    logic [6:0] addr;
    logic [7:0] ctrl_reg;
    logic [7:0] yaw_l;
    logic [7:0] yaw_h;
    logic       int_flag;
    logic [7:0] rx_byte;
    logic [7:0] rd_mux;

    // Byte completed by the current rise: command byte on rise 8, data byte on rise 16
    assign rx_byte = {rx_shft, mosi_s};

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        rd_mux = 8'h00;
        if (rx_byte[6:0] == ADDR_WHO) begin
            rd_mux = WHO_AM_I_VAL;
        end else if (rx_byte[6:0] == ADDR_CTRL) begin
            rd_mux = ctrl_reg;
        end else if (rx_byte[6:0] == ADDR_YAWL) begin
            rd_mux = yaw_l;
        end else if (rx_byte[6:0] == ADDR_YAWH) begin
            rd_mux = yaw_h;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            rx_shft    <= '0;
            tx_shft    <= '0;
            rw         <= 1'b0;
            addr       <= '0;
            ctrl_reg   <= '0;
            yaw_l      <= '0;
            yaw_h      <= '0;
            int_flag   <= 1'b0;
            nemo_setup <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (ss_fall) begin
                        state   <= CMD;
                        bit_cnt <= '0;
                        rx_shft <= '0;
                        tx_shft <= '0;
                    end
                end
                CMD: begin
                    if (ss_sync) begin
                        state <= IDLE;
                    end else if (sclk_rise) begin
                        rx_shft <= rx_byte[6:0];
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == LAST_CMD_BIT) begin
                            rw      <= rx_byte[7];
                            addr    <= rx_byte[6:0];
                            tx_shft <= rd_mux;
                            state   <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (ss_sync) begin
                        state <= IDLE;
                    end else if (sclk_rise) begin
                        rx_shft <= rx_byte[6:0];
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == LAST_FRAME_BIT) begin
                            if (!rw && addr == ADDR_CTRL) begin
                                ctrl_reg <= rx_byte;
                                if (rx_byte == SETUP_VAL) begin
                                    nemo_setup <= 1'b1;
                                end
                            end
                            if (rw && addr == ADDR_YAWH) begin
                                int_flag <= 1'b0;
                            end
                            done  <= 1'b1;
                            state <= HOLD;
                        end
                    end else if (sclk_fall && bit_cnt >= FIRST_SHIFT_BIT) begin
                        tx_shft <= {tx_shft[6:0], 1'b0};
                    end
                end
                HOLD: begin
                    if (ss_sync) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // A new sample outranks the read-clear of INT landing in the same clk
            if (yaw_vld) begin
                yaw_l    <= yaw_data[7:0];
                yaw_h    <= yaw_data[15:8];
                int_flag <= 1'b1;
            end
        end
    end

    assign MISO = (state == DATA) ? tx_shft[7] : 1'b0;
    assign INT  = int_flag;

endmodule

// File: tb/tb_spi_serf_imu.sv
// Self-checking bench for spi_serf_imu: directed protocol steps then randomized frames,
// all checked against a register-level model of the sensor.
module tb_spi_serf_imu;

    localparam int HALF = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;
    logic        MISO;
    logic        INT;
    logic        nemo_setup;
    logic        yaw_vld;
    logic [15:0] yaw_data;
    logic        done;

    spi_serf_imu dut (
        .clk        (clk),
        .rst        (rst),
        .SS_n       (SS_n),
        .SCLK       (SCLK),
        .MOSI       (MOSI),
        .MISO       (MISO),
        .INT        (INT),
        .nemo_setup (nemo_setup),
        .yaw_vld    (yaw_vld),
        .yaw_data   (yaw_data),
        .done       (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int done_cnt = 0;
    bit watch_int = 1'b0;
    bit int_dropped = 1'b0;

    // Sensor register model
    logic [7:0] m_ctrl;
    logic [7:0] m_yl;
    logic [7:0] m_yh;
    logic       m_int;
    logic       m_setup;

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
    end

    always @(negedge clk) begin
        if (watch_int) begin
            if (INT !== 1'b1) int_dropped = 1'b1;
        end else begin
            int_dropped = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_ctrl  = 8'h00;
        m_yl    = 8'h00;
        m_yh    = 8'h00;
        m_int   = 1'b0;
        m_setup = 1'b0;
    endtask

    function automatic logic [7:0] model_read(input logic [6:0] a);
        if (a == 7'h0F) return 8'h6A;
        if (a == 7'h0D) return m_ctrl;
        if (a == 7'h26) return m_yl;
        if (a == 7'h27) return m_yh;
        return 8'h00;
    endfunction

    task automatic half_sclk();
        repeat (HALF) @(negedge clk);
    endtask

    task automatic ss_begin();
        SS_n = 1'b0;
        half_sclk();
    endtask

    task automatic ss_end();
        SS_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    // Monarch side: drive MOSI after each fall, sample MISO at each rise
    task automatic spi_bits(input logic [15:0] frame, input int nbits, input bit vld_last,
                            input logic [15:0] vld_word, output logic [15:0] rx);
        rx = '0;
        for (int i = 0; i < nbits; i++) begin
            SCLK = 1'b0;
            MOSI = frame[15-i];
            half_sclk();
            SCLK = 1'b1;
            rx = {rx[14:0], MISO};
            if (vld_last && i == 15) begin
                // two sync flops later the FSM acts on this rise; pulse yaw_vld into that clk
                @(negedge clk);
                @(negedge clk);
                yaw_vld  = 1'b1;
                yaw_data = vld_word;
                @(negedge clk);
                yaw_vld  = 1'b0;
                repeat (HALF - 3) @(negedge clk);
            end else begin
                half_sclk();
            end
        end
    endtask

    task automatic frame_full(input logic [15:0] f, input bit vld_last, input logic [15:0] vld_word,
                              input string tag, output logic [7:0] rd);
        logic [15:0] rx;
        logic [7:0]  exp_rd;
        logic [6:0]  a;
        bit          is_rd;
        int          d0;
        is_rd  = f[15];
        a      = f[14:8];
        exp_rd = model_read(a);
        d0     = done_cnt;
        ss_begin();
        spi_bits(f, 16, vld_last, vld_word, rx);
        ss_end();
        if (is_rd && a == 7'h27) m_int = 1'b0;
        if (!is_rd && a == 7'h0D) begin
            m_ctrl = f[7:0];
            if (f[7:0] == 8'h02) m_setup = 1'b1;
        end
        if (vld_last) begin
            m_yl  = vld_word[7:0];
            m_yh  = vld_word[15:8];
            m_int = 1'b1;
        end
        rd = rx[7:0];
        check($sformatf("%s done pulses", tag), done_cnt - d0, 1);
        check($sformatf("%s cmd-phase MISO", tag), rx[15:8], 8'h00);
        if (is_rd) check($sformatf("%s read data", tag), rx[7:0], exp_rd);
        check($sformatf("%s INT", tag), INT, m_int);
        check($sformatf("%s nemo_setup", tag), nemo_setup, m_setup);
    endtask

    task automatic pulse_yaw(input logic [15:0] w);
        @(negedge clk);
        yaw_vld  = 1'b1;
        yaw_data = w;
        @(negedge clk);
        yaw_vld  = 1'b0;
        m_yl  = w[7:0];
        m_yh  = w[15:8];
        m_int = 1'b1;
        @(negedge clk);
        check("yaw_vld sets INT", INT, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0]  rd;
        logic [15:0] rx;
        logic [6:0]  a;
        logic [7:0]  d;
        int          d0;
        logic [6:0]  addr_tab [5];

        addr_tab = '{7'h0F, 7'h0D, 7'h26, 7'h27, 7'h00};
        rst = 1'b1; SS_n = 1'b1; SCLK = 1'b1; MOSI = 1'b0; yaw_vld = 1'b0; yaw_data = '0;
        model_reset();
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset MISO", MISO, 1'b0);
        check("reset INT", INT, 1'b0);
        check("reset nemo_setup", nemo_setup, 1'b0);
        check("reset done", done, 1'b0);

        frame_full(16'h8F00, 1'b0, '0, "who_am_i", rd);
        check("who_am_i value", rd, 8'h6A);

        // Abort a setup write after 12 bits
        d0 = done_cnt;
        ss_begin();
        spi_bits(16'h0D02, 12, 1'b0, '0, rx);
        ss_end();
        check("abort no done", done_cnt - d0, 0);
        check("abort nemo_setup", nemo_setup, 1'b0);
        frame_full(16'h8D00, 1'b0, '0, "ctrl after abort", rd);
        frame_full(16'h8F00, 1'b0, '0, "who after abort", rd);
        check("who after abort value", rd, 8'h6A);

        // Setup handshake and stickiness
        frame_full(16'h0D02, 1'b0, '0, "setup write", rd);
        check("setup sets flag", nemo_setup, 1'b1);
        frame_full(16'h8D00, 1'b0, '0, "ctrl read", rd);
        check("ctrl read value", rd, 8'h02);
        frame_full(16'h0D05, 1'b0, '0, "ctrl rewrite", rd);
        frame_full(16'h8D00, 1'b0, '0, "ctrl reread", rd);
        check("ctrl reread value", rd, 8'h05);
        check("setup sticky", nemo_setup, 1'b1);

        // Yaw samples and INT
        pulse_yaw(16'h998D);
        frame_full(16'hA600, 1'b0, '0, "yawL 1", rd);
        check("yawL 1 value", rd, 8'h8D);
        frame_full(16'hA700, 1'b0, '0, "yawH 1", rd);
        check("yawH 1 value", rd, 8'h99);
        check("INT cleared by yawH", INT, 1'b0);
        pulse_yaw(16'hCD3D);
        frame_full(16'hA600, 1'b0, '0, "yawL 2", rd);
        check("yawL 2 value", rd, 8'h3D);
        frame_full(16'hA700, 1'b0, '0, "yawH 2", rd);
        check("yawH 2 value", rd, 8'hCD);

        // New sample landing on the clk of the INT-clearing rise
        pulse_yaw(16'h1234);
        watch_int = 1'b1;
        frame_full(16'hA700, 1'b1, 16'h5A7E, "yawH collide", rd);
        watch_int = 1'b0;
        check("yawH collide old value", rd, 8'h12);
        check("INT never dropped", int_dropped, 1'b0);
        @(negedge clk);
        frame_full(16'hA600, 1'b0, '0, "yawL new", rd);
        check("yawL new value", rd, 8'h7E);

        // Reset during bit 10 of a yaw read
        pulse_yaw(16'hBEEF);
        d0 = done_cnt;
        ss_begin();
        spi_bits(16'hA600, 10, 1'b0, '0, rx);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check("mid reset MISO", MISO, 1'b0);
        check("mid reset INT", INT, 1'b0);
        check("mid reset nemo_setup", nemo_setup, 1'b0);
        ss_end();
        check("mid reset no done", done_cnt - d0, 0);
        frame_full(16'hA600, 1'b0, '0, "yawL after reset", rd);
        check("yawL after reset value", rd, 8'h00);

        // Randomized traffic against the model
        for (int n = 0; n < 40; n++) begin
            int k;
            if ($urandom_range(0, 9) < 3) pulse_yaw(16'($urandom));
            k = int'($urandom_range(0, 4));
            a = (k == 4) ? 7'($urandom) : addr_tab[k];
            d = ($urandom_range(0, 3) == 0) ? 8'h02 : 8'($urandom);
            frame_full({1'($urandom), a, d}, 1'b0, '0, $sformatf("rand %0d", n), rd);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
